// File: rtl/dsi_long_pkt_builder_pkg.sv
// dsi_pkg: shared types and constants for the DSI transmit packet path.
//   FRAME_LENGTH_DEF : default pixels per line packet (24 bits each)
//   WC_W             : word-count / byte-counter width
//   state_e          : long-packet builder sequencing states
//   DT_RGB888        : DSI data type for packed 24-bit pixels
//   HDR_BYTES/FTR_BYTES : fixed header and CRC footer sizes
package dsi_pkg;
    localparam int FRAME_LENGTH_DEF = 4;
    localparam int WC_W             = 16;
    localparam int HDR_BYTES        = 4;
    localparam int FTR_BYTES        = 2;

    localparam logic [5:0] DT_RGB888 = 6'h3E;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        FTR  = 2'd3
    } state_e;
endpackage

// File: rtl/dsi_long_pkt_builder_if.sv
// Bus between the payload CRC stage, the long-packet builder and the lane side.
//   payload/crc/crc_done/vc/dt : capture side (driven by the CRC stage)
//   byte_out/byte_valid/byte_ready : byte stream with valid/ready handshake
//   pkt_start/pkt_end          : first header byte / last footer byte markers
//   busy/drop_err              : status
// master = builder, slave = the environment around it.
interface dsi_long_pkt_builder_if
    import dsi_pkg::*;
#(
    parameter int FRAME_LENGTH = FRAME_LENGTH_DEF
) ();
    logic [FRAME_LENGTH*24-1:0] payload;
    logic [15:0]                crc;
    logic                       crc_done;
    logic [1:0]                 vc;
    logic [5:0]                 dt;
    logic [7:0]                 byte_out;
    logic                       byte_valid;
    logic                       byte_ready;
    logic                       pkt_start;
    logic                       pkt_end;
    logic                       busy;
    logic                       drop_err;

    modport master (
        input  payload, crc, crc_done, vc, dt, byte_ready,
        output byte_out, byte_valid, pkt_start, pkt_end, busy, drop_err
    );

    modport slave (
        output payload, crc, crc_done, vc, dt, byte_ready,
        input  byte_out, byte_valid, pkt_start, pkt_end, busy, drop_err
    );
endinterface

// File: rtl/dsi_long_pkt_builder_ecc.sv
// dsi_ecc: combinational MIPI DSI packet-header Hamming encoder.
//   data_i : {WC MSB, WC LSB, DI}, bit 0 = DI[0]
//   ecc_o  : 6-bit ECC (P5..P0)
// Each parity bit is the XOR of the data bits selected by its mask.
module dsi_ecc (
    input  logic [23:0] data_i,
    output logic [5:0]  ecc_o
);
    localparam logic [23:0] M0 = 24'hF12CB7;
    localparam logic [23:0] M1 = 24'hF2555B;
    localparam logic [23:0] M2 = 24'h749A6D;
    localparam logic [23:0] M3 = 24'hB8E38E;
    localparam logic [23:0] M4 = 24'hDF03F0;
    localparam logic [23:0] M5 = 24'hEFFC00;

    assign ecc_o = {^(data_i & M5), ^(data_i & M4), ^(data_i & M3),
                    ^(data_i & M2), ^(data_i & M1), ^(data_i & M0)};
endmodule

// File: rtl/dsi_long_pkt_builder.sv
// dsi_long_pkt_builder: captures a line payload + CRC on crc_done and streams
// a DSI long packet (DI, WC LSB, WC MSB, ECC, payload, CRC LSB, CRC MSB).
//   dsi_clk : clock, all logic on posedge
//   dsi_rst : asynchronous active-high reset
//   bus     : dsi_long_pkt_builder_if.master (capture inputs, byte stream, status)
module dsi_long_pkt_builder
    import dsi_pkg::*;
#(
    parameter int FRAME_LENGTH = FRAME_LENGTH_DEF
) (
    input logic                    dsi_clk,
    input logic                    dsi_rst,
    dsi_long_pkt_builder_if.master bus
);
    localparam int              PAY_W = FRAME_LENGTH * 24;
    localparam logic [WC_W-1:0] WC    = WC_W'(3 * FRAME_LENGTH);

    state_e          state_q, state_d;
    logic [WC_W-1:0] cnt_q, cnt_d;
    logic [PAY_W-1:0] pay_q, pay_d;
    logic [15:0]     crc_q, crc_d;
    logic [7:0]      di_q, di_d;
    logic [7:0]      byte_q, byte_d;
    logic            valid_q, start_q, end_q, busy_q, drop_q;
    logic            accept, last, capture;
    logic [5:0]      ecc6;

    // ECC only ever feeds header byte 3, by which time DI is latched.
    dsi_ecc u_ecc (.data_i({WC, di_q}), .ecc_o(ecc6));

    function automatic logic [WC_W-1:0] sec_len(state_e s);
        case (s)
            HDR:     return WC_W'(HDR_BYTES);
            PAY:     return WC;
            FTR:     return WC_W'(FTR_BYTES);
            default: return '0;
        endcase
    endfunction

    always_comb begin
        accept  = valid_q & bus.byte_ready;
        last    = (cnt_q == sec_len(state_q) - 1'b1);
        // A new line may be taken when idle or exactly on the final footer accept.
        capture = bus.crc_done & ((state_q == IDLE) | ((state_q == FTR) & accept & last));
        state_d = state_q;
        cnt_d   = cnt_q;
        if (capture) begin
            state_d = HDR;
            cnt_d   = '0;
        end else if (accept) begin
            if (last) begin
                cnt_d = '0;
                case (state_q)
                    HDR:     state_d = PAY;
                    PAY:     state_d = FTR;
                    default: state_d = IDLE;
                endcase
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        pay_d = capture ? bus.payload : pay_q;
        crc_d = capture ? bus.crc : crc_q;
        di_d  = capture ? {bus.vc, bus.dt} : di_q;
    end

    // Output byte is a pure function of the next position, so a stall
    // (no change of state/count) holds it stable automatically.
    always_comb begin
        byte_d = 8'h00;
        case (state_d)
            HDR: begin
                case (cnt_d[1:0])
                    2'd0:    byte_d = di_d;
                    2'd1:    byte_d = WC[7:0];
                    2'd2:    byte_d = WC[15:8];
                    default: byte_d = {2'b00, ecc6};
                endcase
            end
            PAY:     byte_d = 8'(pay_d >> {cnt_d, 3'b000});
            FTR:     byte_d = cnt_d[0] ? crc_d[15:8] : crc_d[7:0];
            default: byte_d = 8'h00;
        endcase
    end

    always_ff @(posedge dsi_clk or posedge dsi_rst) begin
        if (dsi_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pay_q   <= '0;
            crc_q   <= '0;
            di_q    <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pay_q   <= pay_d;
            crc_q   <= crc_d;
            di_q    <= di_d;
            byte_q  <= byte_d;
            valid_q <= (state_d != IDLE);
            start_q <= (state_d == HDR) && (cnt_d == '0);
            end_q   <= (state_d == FTR) && (cnt_d == WC_W'(FTR_BYTES - 1));
            busy_q  <= (state_d != IDLE);
            drop_q  <= drop_q | (bus.crc_done & ~capture);
        end
    end

    assign bus.byte_out   = byte_q;
    assign bus.byte_valid = valid_q;
    assign bus.pkt_start  = start_q;
    assign bus.pkt_end    = end_q;
    assign bus.busy       = busy_q;
    assign bus.drop_err   = drop_q;
endmodule

// File: tb/tb_dsi_long_pkt_builder.sv
// Randomized bench for dsi_long_pkt_builder with a queue-based packet model.
module tb_dsi_long_pkt_builder;
    import dsi_pkg::*;

    localparam int FL  = 4;
    localparam int WC  = 3 * FL;
    localparam int PKT = 4 + WC + 2;
    localparam logic [FL*24-1:0] PAY_LIT = 96'h0C0B0A090807060504030201;

    // DSI ECC column codes: parity bits covering each data bit.
    localparam logic [5:0] ECC_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

    logic dsi_clk = 1'b0;
    logic dsi_rst = 1'b0;
    always #5 dsi_clk = ~dsi_clk;

    dsi_long_pkt_builder_if #(.FRAME_LENGTH(FL)) bus ();
    dsi_long_pkt_builder #(.FRAME_LENGTH(FL)) dut (
        .dsi_clk(dsi_clk), .dsi_rst(dsi_rst), .bus(bus));

    logic [23:0] ecc_in;
    logic [5:0]  ecc_out;
    dsi_ecc u_ecc (.data_i(ecc_in), .ecc_o(ecc_out));

    typedef struct { logic [7:0] b; bit s; bit e; } ent_t;
    typedef struct { logic [7:0] b; bit s; bit e; int cyc; } rx_t;

    ent_t exp_q[$];
    rx_t  rx_log[$];
    bit   m_drop = 0, chk_en = 0, bp = 0;
    int   cyc = 0;
    int   tests = 0, fails = 0;
    logic [7:0] cur_b = '0;
    logic cur_s = 1'b0, cur_e = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] ecc_model(logic [23:0] d);
        logic [5:0] p = '0;
        for (int i = 0; i < 24; i++) if (d[i]) p ^= ECC_COL[i];
        return p;
    endfunction

    function automatic void push_pkt(logic [1:0] vc, logic [5:0] dt,
                                     logic [FL*24-1:0] pay, logic [15:0] crc);
        logic [7:0]  bytes [PKT];
        logic [7:0]  di = {vc, dt};
        logic [15:0] wc = 16'(WC);
        bytes[0] = di;
        bytes[1] = wc[7:0];
        bytes[2] = wc[15:8];
        bytes[3] = {2'b00, ecc_model({wc, di})};
        for (int k = 0; k < WC; k++) bytes[4+k] = pay[8*k +: 8];
        bytes[4+WC] = crc[7:0];
        bytes[5+WC] = crc[15:8];
        for (int k = 0; k < PKT; k++)
            exp_q.push_back('{b: bytes[k], s: (k == 0), e: (k == PKT-1)});
    endfunction

    // Model advance at each edge, then one compare of all outputs.
    initial begin
        forever begin
            @(posedge dsi_clk);
            cyc++;
            if (chk_en && !dsi_rst) begin
                bit acc, cap;
                acc = (exp_q.size() != 0) && bus.byte_ready;
                cap = bus.crc_done && (exp_q.size() == 0 || (exp_q.size() == 1 && acc));
                if (bus.crc_done && !cap) m_drop = 1;
                if (acc) begin
                    void'(exp_q.pop_front());
                    rx_log.push_back('{b: cur_b, s: cur_s, e: cur_e, cyc: cyc});
                end
                if (cap) push_pkt(bus.vc, bus.dt, bus.payload, bus.crc);
                #1;
                if (!dsi_rst) begin
                    check("valid", bus.byte_valid, exp_q.size() != 0);
                    check("busy", bus.busy, exp_q.size() != 0);
                    check("drop_err", bus.drop_err, m_drop);
                    if (exp_q.size() != 0) begin
                        check("byte", bus.byte_out, exp_q[0].b);
                        check("pkt_start", bus.pkt_start, exp_q[0].s);
                        check("pkt_end", bus.pkt_end, exp_q[0].e);
                    end else begin
                        check("pkt_start idle", bus.pkt_start, 0);
                        check("pkt_end idle", bus.pkt_end, 0);
                    end
                    cur_b = bus.byte_out;
                    cur_s = bus.pkt_start;
                    cur_e = bus.pkt_end;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge dsi_clk);
        bus.byte_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic fire(logic [1:0] vc, logic [5:0] dt, logic [FL*24-1:0] pay, logic [15:0] crc);
        bus.vc = vc; bus.dt = dt; bus.payload = pay; bus.crc = crc;
        bus.crc_done = 1'b1;
        tick();
        bus.crc_done = 1'b0;
    endtask

    task automatic wait_done(string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 2000) begin tick(); n++; end
        check({name, " completes"}, n < 2000, 1);
    endtask

    // Incrementing-payload packet against hand-computed bytes.
    task automatic check_lit(string name, int base, logic [7:0] di, logic [7:0] ecc, logic [15:0] crc);
        logic [7:0] e;
        check({name, " byte count"}, rx_log.size() - base >= PKT, 1);
        if (rx_log.size() - base >= PKT) begin
            for (int k = 0; k < PKT; k++) begin
                e = (k == 0) ? di : (k == 1) ? 8'h0C : (k == 2) ? 8'h00 : (k == 3) ? ecc :
                    (k < 4 + WC) ? 8'(k - 3) : (k == 4 + WC) ? crc[7:0] : crc[15:8];
                check($sformatf("%s byte%0d", name, k), rx_log[base+k].b, e);
                check($sformatf("%s start%0d", name, k), rx_log[base+k].s, k == 0);
                check($sformatf("%s end%0d", name, k), rx_log[base+k].e, k == PKT - 1);
            end
        end
    endtask

    initial begin
        int base, cap_cyc, n, oldbase;
        bus.crc_done = 0; bus.byte_ready = 1; bus.payload = '0;
        bus.crc = '0; bus.vc = '0; bus.dt = '0; ecc_in = '0;
        #1 dsi_rst = 1'b1;
        repeat (3) @(negedge dsi_clk);
        check("rst byte_out", bus.byte_out, 0);
        check("rst byte_valid", bus.byte_valid, 0);
        check("rst pkt_start", bus.pkt_start, 0);
        check("rst pkt_end", bus.pkt_end, 0);
        check("rst busy", bus.busy, 0);
        check("rst drop_err", bus.drop_err, 0);
        dsi_rst = 1'b0;
        chk_en = 1;

        // Basic packet, ready held high.
        tick();
        base = rx_log.size();
        fire(2'd0, DT_RGB888, PAY_LIT, 16'hBEEF);
        cap_cyc = cyc;
        wait_done("basic");
        check_lit("basic", base, 8'h3E, 8'h08, 16'hBEEF);
        if (rx_log.size() - base >= PKT) begin
            check("basic latency", rx_log[base].cyc, cap_cyc + 1);
            check("basic duration", rx_log[base+PKT-1].cyc - rx_log[base].cyc, PKT - 1);
        end

        // ECC of a vc=0/dt=0 header and the encoder on its own.
        tick();
        base = rx_log.size();
        fire(2'd0, 6'h00, {$urandom, $urandom, $urandom}, 16'($urandom));
        wait_done("ecc pkt");
        if (rx_log.size() - base >= PKT) begin
            check("ecc hdr0", rx_log[base].b, 8'h00);
            check("ecc hdr1", rx_log[base+1].b, 8'h0C);
            check("ecc hdr2", rx_log[base+2].b, 8'h00);
            check("ecc hdr3 literal", rx_log[base+3].b, 8'h06);
            check("ecc hdr3 model", rx_log[base+3].b, {2'b00, ecc_model(24'h000C00)});
        end
        ecc_in = '0;
        #1 check("ecc zero", ecc_out, 6'h00);
        for (int i = 0; i < 16; i++) begin
            ecc_in = 24'($urandom);
            #1 check("ecc random", ecc_out, ecc_model(ecc_in));
        end

        // Backpressure.
        bp = 1;
        tick();
        base = rx_log.size();
        fire(2'd0, DT_RGB888, PAY_LIT, 16'hBEEF);
        wait_done("backpressure");
        check_lit("backpressure", base, 8'h3E, 8'h08, 16'hBEEF);
        bp = 0;

        // Back-to-back on the final footer accept.
        tick();
        base = rx_log.size();
        fire(2'd0, DT_RGB888, PAY_LIT, 16'hBEEF);
        n = 0;
        while (!(exp_q.size() == 1 && bus.byte_ready) && n < 100) begin tick(); n++; end
        check("b2b sync", n < 100, 1);
        fire(2'd0, DT_RGB888, PAY_LIT, 16'h1234);
        wait_done("b2b");
        check_lit("b2b p1", base, 8'h3E, 8'h08, 16'hBEEF);
        check_lit("b2b p2", base + PKT, 8'h3E, 8'h08, 16'h1234);
        if (rx_log.size() - base >= 2 * PKT)
            check("b2b no gap", rx_log[base+PKT].cyc - rx_log[base+PKT-1].cyc, 1);
        check("b2b drop_err", bus.drop_err, 0);

        // Dropped pulse while in payload.
        tick();
        base = rx_log.size();
        fire(2'd0, DT_RGB888, PAY_LIT, 16'hBEEF);
        n = 0;
        while (rx_log.size() - base < 6 && n < 100) begin tick(); n++; end
        fire(2'd1, 6'h2A, {$urandom, $urandom, $urandom}, 16'hDEAD);
        check("drop_err set", bus.drop_err, 1);
        wait_done("drop");
        check_lit("drop pkt", base, 8'h3E, 8'h08, 16'hBEEF);
        check("drop_err held", bus.drop_err, 1);
        check("drop idle", bus.busy, 0);

        // Reset during payload byte 5.
        tick();
        base = rx_log.size();
        fire(2'd0, DT_RGB888, PAY_LIT, 16'hBEEF);
        n = 0;
        while (rx_log.size() - base < 8 && n < 100) begin tick(); n++; end
        check("midrst at pay5", bus.byte_out, 8'h05);
        oldbase = base;
        #2 dsi_rst = 1'b1;
        exp_q.delete();
        m_drop = 0;
        #1;
        check("midrst byte_out", bus.byte_out, 0);
        check("midrst byte_valid", bus.byte_valid, 0);
        check("midrst pkt_start", bus.pkt_start, 0);
        check("midrst pkt_end", bus.pkt_end, 0);
        check("midrst busy", bus.busy, 0);
        check("midrst drop_err", bus.drop_err, 0);
        tick(); tick();
        dsi_rst = 1'b0;
        check("midrst aborted bytes", rx_log.size() - oldbase, 8);
        tick();
        base = rx_log.size();
        fire(2'd0, DT_RGB888, PAY_LIT, 16'hCAFE);
        wait_done("post-reset");
        check_lit("post-reset", base, 8'h3E, 8'h08, 16'hCAFE);

        // Random traffic: gaps, back-to-back attempts and collisions.
        bp = 1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: repeat ($urandom_range(0, 4)) tick();
                1: begin
                    n = 0;
                    while (exp_q.size() != 1 && n < 200) begin tick(); n++; end
                end
                default: repeat ($urandom_range(0, 20)) tick();
            endcase
            fire(2'($urandom), 6'($urandom), {$urandom, $urandom, $urandom}, 16'($urandom));
        end
        wait_done("random");
        bp = 0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
